// File: rtl/gx4000_cart_reader.sv
// Plus cartridge read path: RMR2 / DFxx mapping registers, ROM window
// decode, and a one-entry cached SDRAM byte reader with req/ack handshake.
module gx4000_cart_reader #(
  parameter logic [24:0] CART_BASE = 25'h0100000,
  parameter int          PAGE_W    = 5
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              plus_mode,
  input  logic              asic_unlocked,
  input  logic              cart_loading,
  input  logic [PAGE_W-1:0] page_mask,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_data_in,
  input  logic              io_wr,
  input  logic              mem_rd,
  input  logic              lower_rom_en,
  input  logic              upper_rom_en,
  output logic              rom_hit,
  output logic [7:0]        cpu_data_out,
  output logic              cpu_ready,
  output logic              asic_page_en,
  output logic [2:0]        lower_page,
  output logic [PAGE_W-1:0] upper_page,
  output logic [24:0]       sdram_addr,
  output logic              sdram_rd,
  input  logic              sdram_ack,
  input  logic [7:0]        sdram_q
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        rmr2;
  logic              loading_q;
  logic              cache_valid;
  logic [24:0]       cache_tag;
  logic [7:0]        cache_data;

  logic              rmr_wr, dfxx_wr, load_rise, cache_inval;
  logic [1:0]        lower_loc;
  logic              lower_hit, upper_hit, cache_hit;
  logic [PAGE_W-1:0] page_sel;
  logic [24:0]       calc_addr;
  logic              ld_ff, ld_cache, ld_req, fill;

  // RMR2 writes need the ASIC unlocked and the 101xxxxx signature
  assign rmr_wr      = plus_mode & io_wr & (cpu_addr[15:8] == 8'h7F) &
                       (cpu_data_in[7:5] == 3'b101) & asic_unlocked;
  assign dfxx_wr     = plus_mode & io_wr & (cpu_addr[15:8] == 8'hDF);
  assign load_rise   = cart_loading & ~loading_q;
  assign cache_inval = rmr_wr | dfxx_wr | load_rise;

  assign lower_page   = rmr2[2:0];
  assign asic_page_en = (rmr2[4:3] == 2'b11);

  // location 11 selects the ASIC page at 4000, the lower ROM itself stays at 0000,
  // so the lower window can never land in the upper-ROM quarter
  assign lower_loc = (rmr2[4:3] == 2'b11) ? 2'b00 : rmr2[4:3];
  assign lower_hit = plus_mode & lower_rom_en & (cpu_addr[15:14] == lower_loc);
  assign upper_hit = plus_mode & upper_rom_en & (cpu_addr[15:14] == 2'b11);
  assign rom_hit   = lower_hit | upper_hit;

  assign page_sel  = lower_hit ? PAGE_W'(rmr2[2:0]) : upper_page;
  assign calc_addr = CART_BASE + 25'({page_sel & page_mask, cpu_addr[13:0]});
  assign cache_hit = cache_valid & (cache_tag == calc_addr);

  assign sdram_rd  = (state_q == S_REQ);
  assign cpu_ready = (state_q == S_DONE);
  assign fill      = (state_q == S_REQ) & sdram_ack;

  // mapping registers; DFxx with bit 7 clear falls back to page 1
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rmr2       <= 5'h00;
      upper_page <= PAGE_W'(1);
      loading_q  <= 1'b0;
    end else begin
      loading_q <= cart_loading;
      if (rmr_wr)  rmr2 <= cpu_data_in[4:0];
      if (dfxx_wr) upper_page <= cpu_data_in[7] ? cpu_data_in[PAGE_W-1:0] : PAGE_W'(1);
    end
  end

  // read FSM next state and datapath load enables
  always_comb begin
    state_d  = state_q;
    ld_ff    = 1'b0;
    ld_cache = 1'b0;
    ld_req   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_rd && rom_hit) begin
          if (cart_loading) begin
            state_d = S_DONE;
            ld_ff   = 1'b1;
          end else if (cache_hit) begin
            state_d  = S_DONE;
            ld_cache = 1'b1;
          end else begin
            state_d = S_REQ;
            ld_req  = 1'b1;
          end
        end
      end
      S_REQ:   if (sdram_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state, latched request address and read data
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sdram_addr   <= 25'h0;
      cpu_data_out <= 8'hFF;
    end else begin
      state_q <= state_d;
      if (ld_req)   sdram_addr   <= calc_addr;
      if (ld_ff)    cpu_data_out <= 8'hFF;
      if (ld_cache) cpu_data_out <= cache_data;
      if (fill)     cpu_data_out <= sdram_q;
    end
  end

  // one-entry read cache tagged by full SDRAM address; invalidation wins over fill
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_tag   <= 25'h0;
      cache_data  <= 8'h00;
    end else begin
      if (fill) begin
        cache_valid <= 1'b1;
        cache_tag   <= sdram_addr;
        cache_data  <= sdram_q;
      end
      if (cache_inval) cache_valid <= 1'b0;
    end
  end

endmodule

// File: doc/gx4000_cart_reader.md
Name: gx4000_cart_reader

Overview:
- Read-side counterpart of the Plus cartridge loader: the loader writes the cartridge image into SDRAM; this block serves Z80 ROM reads from it.
- Holds the Plus ROM-mapping registers: RMR2 for the lower ROM and the DFxx upper-ROM select.
- Translates CPU ROM-window reads into SDRAM byte reads with a req/ack handshake, backed by a one-entry read cache.
- Sits between the CPU bus decode and the SDRAM arbiter, beside the ASIC and I/O blocks.

Parameters:
- CART_BASE, 25'h0100000, SDRAM byte address of cartridge page 0.
- PAGE_W, 5, page-number width (32 pages of 16 KB = 512 KB).

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- plus_mode  in  1  block active; when 0, no requests are serviced and I/O writes are ignored.
- asic_unlocked  in  1  ASIC unlock sequence completed; RMR2 writes accepted only when 1.
- cart_loading  in  1  cartridge download in progress.
- page_mask  in  PAGE_W  valid-page mask (cartridge size − 1 in pages).
- cpu_addr  in  16  CPU address.
- cpu_data_in  in  8  CPU write data.
- io_wr  in  1  single-cycle I/O write strobe.
- mem_rd  in  1  single-cycle memory read strobe.
- lower_rom_en  in  1  RMR lower-ROM enable.
- upper_rom_en  in  1  RMR upper-ROM enable.
- rom_hit  out  1  combinational: cpu_addr falls in an enabled cartridge window.
- cpu_data_out  out  8  read data, valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle read-complete pulse.
- asic_page_en  out  1  RMR2[4:3]==2'b11; ASIC registers are mapped at 4000–7FFF.
- lower_page  out  3  RMR2[2:0].
- upper_page  out  PAGE_W  current upper-ROM cartridge page.
- sdram_addr  out  25  SDRAM read address.
- sdram_rd  out  1  read request, level, held until ack.
- sdram_ack  in  1  one-cycle acknowledge; sdram_q valid in the same cycle.
- sdram_q  in  8  SDRAM read data.

Behaviour:
- Reset values: RMR2=8'h00 (lower_page=0, location 0000, asic_page_en=0); upper_page=1; cache invalid; state IDLE; sdram_rd=0; cpu_ready=0; cpu_data_out=8'hFF; sdram_addr=0.
- I/O decode, io_wr=1 and plus_mode=1:
  - cpu_addr[15:8]==8'h7F, cpu_data_in[7:5]==3'b101, asic_unlocked=1 → RMR2 <= cpu_data_in[4:0].
  - cpu_addr[15:8]==8'hDF → upper_page <= cpu_data_in[7] ? cpu_data_in[PAGE_W-1:0] : 1.
  - Both registers take effect the next cycle. They do not alter an in-flight request (its address is already latched). Either write invalidates the cache.
- Window decode (rom_hit):
  - Lower window: lower_rom_en=1 and cpu_addr[15:14] equals the RMR2[4:3] location (00→0, 01→1, 10→2, 11→0). Page = RMR2[2:0].
  - Upper window: upper_rom_en=1 and cpu_addr[15:14]==2'b11. Page = upper_page.
  - The windows cannot overlap. rom_hit=0 when plus_mode=0.
- Address: sdram_addr = CART_BASE + {(page & page_mask), cpu_addr[13:0]}, 25-bit unsigned, wrap-around ignored.
- FSM states IDLE, REQ, DONE.
  - IDLE, mem_rd & rom_hit & cart_loading → DONE with data 8'hFF; no SDRAM access.
  - IDLE, mem_rd & rom_hit, cache valid and tag equals the computed address → DONE with cached data. Latency 1 cycle (cpu_ready the cycle after mem_rd).
  - IDLE, mem_rd & rom_hit, cache miss → latch sdram_addr, go to REQ, assert sdram_rd.
  - REQ: hold sdram_rd and sdram_addr stable until sdram_ack. On ack: drop sdram_rd, capture sdram_q into cpu_data_out and the cache (tag = address, valid=1), go to DONE. Minimum latency mem_rd→cpu_ready is 2 cycles when ack arrives in the first REQ cycle.
  - DONE: cpu_ready=1 for exactly one cycle, then IDLE. cpu_data_out holds its value until the next completion.
  - mem_rd with rom_hit=0 → no action.
  - mem_rd outside IDLE → ignored (protocol violation; bench flags it).
- cart_loading rising edge invalidates the cache.
- sdram_ack outside REQ is ignored.
- Reset mid-REQ: sdram_rd=0 on the next edge; a late ack is ignored.

Test Plan:
- RMR2 write 7F00←8'hA2 with asic_unlocked=1, lower_rom_en=1, mem_rd @0123, ack after 3 cycles with q=8'h5A → sdram_addr=25'h0108123; cpu_ready one cycle; cpu_data_out=8'h5A.
- Repeat the same read → cpu_ready one cycle after mem_rd; sdram_rd never asserted; data=8'h5A. Then write DF00←8'h85 → cache invalidated; next read of @0123 issues sdram_rd.
- DF00←8'h83, upper_rom_en=1, page_mask=5'h01, read @C010 → sdram_addr=25'h0104010 (page 3 masked to 1).
- RMR2 write 7F00←8'hB8 with asic_unlocked=0 → RMR2 unchanged; with asic_unlocked=1 → asic_page_en=1, lower window at 0000, page 0.
- cart_loading=1, read @0000 → cpu_ready the cycle after mem_rd, data 8'hFF, sdram_rd stays 0.
- Reset asserted during REQ, then ack pulses → sdram_rd=0 after reset, cpu_ready never asserted, all outputs at reset values.
